// File: rtl/stack_op_if.sv
// stack_op_if: decoder handshake plus stack push/pop bus between the sequencer (master) and its environment (slave)
interface stack_op_if;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] op_code;
  logic [3:0] op_imm;
  logic       op_done;
  logic [1:0] op_err;
  logic       stk_push_en;
  logic       stk_pop_en;
  logic [3:0] stk_push_data;
  logic [3:0] stk_tos;
  logic [3:0] stk_ntos;
  modport master (
    input  op_valid, op_code, op_imm, stk_tos, stk_ntos,
    output op_ready, op_done, op_err, stk_push_en, stk_pop_en, stk_push_data
  );
  modport slave (
    output op_valid, op_code, op_imm, stk_tos, stk_ntos,
    input  op_ready, op_done, op_err, stk_push_en, stk_pop_en, stk_push_data
  );
endinterface

// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: issues 1-3 stack cycles per accepted instruction; ports clk, rst, bus (stack_op_if.master), depth, carry
module stack_op_sequencer #(
  parameter int STACK_DEPTH = 16,
  parameter int DEPTH_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  stack_op_if.master         bus,
  output logic [DEPTH_W-1:0] depth,
  output logic               carry
);
  typedef enum logic [1:0] {IDLE, EX2, EX3} state_t;
  state_t state, state_n;
  logic [3:0] op_q, a_q, b_q, c, data;
  logic [4:0] alu;
  logic [1:0] fcode;
  logic need1, need2, grow, uf, of, acc, ok, push, pop, done;
  assign c = bus.op_code;
  assign need1 = c == 4'd2 || c == 4'd3 || c == 4'd10;
  assign need2 = c == 4'd4 || (c >= 4'd5 && c <= 4'd9) || c == 4'd11;
  assign grow = c == 4'd1 || c == 4'd3 || c == 4'd11;
  assign uf = need2 ? depth < DEPTH_W'(2) : need1 && depth == '0;
  assign of = grow && depth == DEPTH_W'(STACK_DEPTH);
  assign fcode = c >= 4'd12 ? 2'b11 : uf ? 2'b01 : of ? 2'b10 : 2'b00;
  assign acc = bus.op_valid && state == IDLE;
  assign ok = acc && fcode == 2'b00;
  // bit 4 doubles as carry for ADD and borrow for SUB
  assign alu = op_q == 4'd5 ? {1'b0, a_q} + {1'b0, b_q} :
               op_q == 4'd6 ? {1'b0, a_q} - {1'b0, b_q} :
               op_q == 4'd7 ? {1'b0, a_q & b_q} :
               op_q == 4'd8 ? {1'b0, a_q | b_q} : {1'b0, a_q ^ b_q};
  always_comb begin
    state_n = state;
    push = 1'b0;
    pop = 1'b0;
    data = 4'd0;
    done = 1'b0;
    case (state)
      IDLE: if (ok) case (c)
        4'd0: done = 1'b1;
        4'd1: {push, data, done} = {1'b1, bus.op_imm, 1'b1};
        4'd2: {pop, done} = 2'b11;
        4'd3: {push, data, done} = {1'b1, bus.stk_tos, 1'b1};
        4'd10: {push, pop, data, done} = {2'b11, ~bus.stk_tos, 1'b1};
        4'd11: {push, data, done} = {1'b1, bus.stk_ntos, 1'b1};
        default: {pop, state_n} = {1'b1, EX2};
      endcase
      EX2: begin
        {push, pop} = 2'b11;
        data = op_q == 4'd4 ? b_q : alu[3:0];
        done = op_q != 4'd4;
        state_n = op_q == 4'd4 ? EX3 : IDLE;
      end
      EX3: {push, data, done, state_n} = {1'b1, a_q, 1'b1, IDLE};
      default: state_n = IDLE;
    endcase
  end
  // outputs are forced quiet during reset so an abandoned op issues nothing more
  assign bus.op_ready = state == IDLE;
  assign bus.stk_push_en = push && !rst;
  assign bus.stk_pop_en = pop && !rst;
  assign bus.stk_push_data = rst ? 4'd0 : data;
  assign bus.op_done = done && !rst;
  assign bus.op_err = acc && !rst ? fcode : 2'b00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      depth <= '0;
      carry <= 1'b0;
      op_q <= 4'd0;
      a_q <= 4'd0;
      b_q <= 4'd0;
    end else begin
      state <= state_n;
      if (acc) {op_q, a_q, b_q} <= {c, bus.stk_ntos, bus.stk_tos};
      if (push && !pop) depth <= depth + DEPTH_W'(1);
      else if (pop && !push) depth <= depth - DEPTH_W'(1);
      if (state == EX2 && (op_q == 4'd5 || op_q == 4'd6)) carry <= alu[4];
    end
  end
endmodule
